// File: rtl/request_input_dispatch_if.sv
// Portal-pipe enqueue and per-method request channels for request_input_dispatch.
// The slave modport is the dispatcher's view; the master modport is the surrounding logic's view.
interface request_input_dispatch_if #(
  parameter int NUM_METHODS = 4,
  parameter int ID_W        = 32,
  parameter int DATA_W      = 64
);
  logic                   pipe_enq__ENA;
  logic [ID_W+DATA_W-1:0] pipe_enq_v;
  logic                   pipe_enq__RDY;
  logic [NUM_METHODS-1:0] req__ENA;
  logic [DATA_W-1:0]      req_v;
  logic [NUM_METHODS-1:0] req__RDY;
  logic                   busy;
  logic [15:0]            err_count;

  modport slave (
    input  pipe_enq__ENA, pipe_enq_v, req__RDY,
    output pipe_enq__RDY, req__ENA, req_v, busy, err_count
  );

  modport master (
    output pipe_enq__ENA, pipe_enq_v, req__RDY,
    input  pipe_enq__RDY, req__ENA, req_v, busy, err_count
  );
endinterface

// File: rtl/request_input_dispatch.sv
// Buffers {payload, method id} messages in a small FIFO and dispatches the head to one of
// NUM_METHODS channels. Define REQUEST_DISPATCH_ERRCNT_EN to count dropped unknown ids.
module request_input_dispatch #(
  parameter int NUM_METHODS = 4,
  parameter int ID_W        = 32,
  parameter int DATA_W      = 64,
  parameter int BASE_ID     = 1,
  parameter int DEPTH       = 2
) (
  input logic CLK,
  input logic RST,
  request_input_dispatch_if.slave io
);
  localparam int              AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]     FULL = (AW+1)'(DEPTH);
  localparam logic [ID_W-1:0] BASE = ID_W'(BASE_ID);
  localparam logic [ID_W-1:0] NM   = ID_W'(NUM_METHODS);

  logic [ID_W+DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wptr, r_rptr;
  logic [AW:0]            r_count;

  logic                   w_busy, w_full, w_enq, w_deq, w_valid, w_drop;
  logic [ID_W+DATA_W-1:0] w_head;
  logic [ID_W-1:0]        w_idx;
  logic [NUM_METHODS-1:0] w_ena;

  assign w_busy  = (r_count != '0);
  assign w_full  = (r_count == FULL);
  assign w_enq   = io.pipe_enq__ENA & ~w_full;
  assign w_head  = r_mem[r_rptr];
  // Unsigned wrap makes ids below BASE_ID land far above NM, so one compare covers both sides.
  assign w_idx   = w_head[ID_W-1:0] - BASE;
  assign w_valid = (w_idx < NM);
  assign w_drop  = w_busy & ~w_valid;
  assign w_deq   = (|w_ena) | w_drop;

  for (genvar g = 0; g < NUM_METHODS; g++) begin : g_ch
    assign w_ena[g] = w_busy & w_valid & (w_idx == ID_W'(g)) & io.req__RDY[g];
  end

  assign io.pipe_enq__RDY = ~w_full;
  assign io.req__ENA      = w_ena;
  assign io.req_v         = w_busy ? w_head[ID_W +: DATA_W] : '0;
  assign io.busy          = w_busy;

  always_ff @(posedge CLK) begin
    if (w_enq) r_mem[r_wptr] <= io.pipe_enq_v;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + AW'(1);
      if (w_deq) r_rptr <= r_rptr + AW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef REQUEST_DISPATCH_ERRCNT_EN
  logic [15:0] r_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                          r_err <= '0;
    else if (w_drop && r_err != '1)   r_err <= r_err + 16'd1;
  end

  assign io.err_count = r_err;
`else
  assign io.err_count = '0;
`endif
endmodule

// File: tb/tb_request_input_dispatch.sv
// Self-checking bench for request_input_dispatch: directed scenarios plus a random run
// checked against a message-queue reference model.
module tb_request_input_dispatch;
  localparam int NM = 4, IDW = 32, DW = 64, DEPTH = 2;

  logic CLK, RST;
  int   total = 0, bad = 0;
  logic [15:0] exp_err;

  request_input_dispatch_if #(.NUM_METHODS(NM), .ID_W(IDW), .DATA_W(DW)) bus ();

  request_input_dispatch #(.NUM_METHODS(NM), .ID_W(IDW), .DATA_W(DW), .BASE_ID(1), .DEPTH(DEPTH))
    dut (.CLK(CLK), .RST(RST), .io(bus.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  typedef struct { logic [31:0] id; logic [63:0] pl; } msg_t;
  msg_t q[$];

  task automatic drive(input logic en, input logic [31:0] id, input logic [63:0] pl, input logic [3:0] rdy);
    bus.pipe_enq__ENA = en;
    bus.pipe_enq_v    = {pl, id};
    bus.req__RDY      = rdy;
  endtask

  function automatic logic [15:0] err_inc(input logic [15:0] e);
`ifdef REQUEST_DISPATCH_ERRCNT_EN
    return (e == 16'hFFFF) ? e : e + 16'd1;
`else
    return e;
`endif
  endfunction

  task automatic test_reset();
    RST = 1'b1;
    drive(1'b0, '0, '0, 4'hF);
    @(negedge CLK); #1;
    total++; if (bus.req__ENA !== 4'b0)     begin bad++; $display("FAIL reset_ena got=%b exp=0000", bus.req__ENA); end
    total++; if (bus.busy !== 1'b0)         begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.pipe_enq__RDY !== 1'b1) begin bad++; $display("FAIL reset_rdy got=%b exp=1", bus.pipe_enq__RDY); end
    total++; if (bus.err_count !== 16'h0)   begin bad++; $display("FAIL reset_err got=%h exp=0000", bus.err_count); end
    RST = 1'b0;
    exp_err = '0;
  endtask

  task automatic test_single();
    logic [63:0] p = 64'h0000_0005_0000_0007;
    @(negedge CLK); drive(1'b1, 32'd1, p, 4'hF); #1;
    total++; if (bus.req__ENA !== 4'b0 || bus.busy !== 1'b0) begin bad++; $display("FAIL single_nobypass ena=%b busy=%b exp 0000/0", bus.req__ENA, bus.busy); end
    @(negedge CLK); drive(1'b0, '0, '0, 4'hF); #1;
    total++; if (bus.req__ENA !== 4'b0001) begin bad++; $display("FAIL single_ena got=%b exp=0001", bus.req__ENA); end
    total++; if (bus.req_v !== p)          begin bad++; $display("FAIL single_v got=%h exp=%h", bus.req_v, p); end
    total++; if (bus.busy !== 1'b1)        begin bad++; $display("FAIL single_busy got=%b exp=1", bus.busy); end
    @(negedge CLK); #1;
    total++; if (bus.busy !== 1'b0 || bus.req__ENA !== 4'b0 || bus.req_v !== 64'h0)
      begin bad++; $display("FAIL single_idle busy=%b ena=%b v=%h exp 0/0000/0", bus.busy, bus.req__ENA, bus.req_v); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ids [3] = '{32'd4, 32'd2, 32'd3};
    logic [3:0]  exp [5] = '{4'b0000, 4'b1000, 4'b0010, 4'b0100, 4'b0000};
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      if (i < 3) drive(1'b1, ids[i], 64'(i + 100), 4'hF); else drive(1'b0, '0, '0, 4'hF);
      #1;
      total++; if (bus.req__ENA !== exp[i]) begin bad++; $display("FAIL b2b_ena[%0d] got=%b exp=%b", i, bus.req__ENA, exp[i]); end
      total++; if (bus.pipe_enq__RDY !== 1'b1) begin bad++; $display("FAIL b2b_rdy[%0d] got=%b exp=1", i, bus.pipe_enq__RDY); end
      if (i >= 1 && i <= 3) begin
        total++; if (bus.req_v !== 64'(i + 99)) begin bad++; $display("FAIL b2b_v[%0d] got=%h exp=%h", i, bus.req_v, 64'(i + 99)); end
      end
    end
  endtask

  task automatic test_stall();
    @(negedge CLK); drive(1'b1, 32'd1, 64'hA1, 4'h0);
    @(negedge CLK); drive(1'b1, 32'd2, 64'hA2, 4'h0);
    @(negedge CLK); drive(1'b1, 32'd1, 64'hA3, 4'h0); #1;
    total++; if (bus.pipe_enq__RDY !== 1'b0 || bus.req__ENA !== 4'b0)
      begin bad++; $display("FAIL stall_full rdy=%b ena=%b exp 0/0000", bus.pipe_enq__RDY, bus.req__ENA); end
    @(negedge CLK); drive(1'b1, 32'd1, 64'hA3, 4'b0001); #1;
    total++; if (bus.req__ENA !== 4'b0001 || bus.req_v !== 64'hA1 || bus.pipe_enq__RDY !== 1'b0)
      begin bad++; $display("FAIL stall_release ena=%b v=%h rdy=%b exp 0001/a1/0", bus.req__ENA, bus.req_v, bus.pipe_enq__RDY); end
    @(negedge CLK); #1;
    total++; if (bus.req__ENA !== 4'b0 || bus.req_v !== 64'hA2 || bus.pipe_enq__RDY !== 1'b1)
      begin bad++; $display("FAIL stall_hol ena=%b v=%h rdy=%b exp 0000/a2/1", bus.req__ENA, bus.req_v, bus.pipe_enq__RDY); end
    @(negedge CLK); drive(1'b0, '0, '0, 4'b0001); #1;
    total++; if (bus.pipe_enq__RDY !== 1'b0 || bus.req__ENA !== 4'b0)
      begin bad++; $display("FAIL stall_third rdy=%b ena=%b exp 0/0000", bus.pipe_enq__RDY, bus.req__ENA); end
    @(negedge CLK); drive(1'b0, '0, '0, 4'hF); #1;
    total++; if (bus.req__ENA !== 4'b0010) begin bad++; $display("FAIL stall_drain1 got=%b exp=0010", bus.req__ENA); end
    @(negedge CLK); #1;
    total++; if (bus.req__ENA !== 4'b0001 || bus.req_v !== 64'hA3)
      begin bad++; $display("FAIL stall_drain2 ena=%b v=%h exp 0001/a3", bus.req__ENA, bus.req_v); end
    @(negedge CLK); #1;
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL stall_empty busy=%b exp=0", bus.busy); end
  endtask

  task automatic test_invalid();
    logic [31:0] ids [3] = '{32'd0, 32'd9, 32'd2};
    logic [3:0]  exp [4] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010};
    for (int i = 0; i < 4; i++) begin
      @(negedge CLK);
      if (i < 3) drive(1'b1, ids[i], 64'hB0 + 64'(i), 4'hF); else drive(1'b0, '0, '0, 4'hF);
      #1;
      total++; if (bus.req__ENA !== exp[i]) begin bad++; $display("FAIL inv_ena[%0d] got=%b exp=%b", i, bus.req__ENA, exp[i]); end
      if (i == 1 || i == 2) exp_err = err_inc(exp_err);
    end
    @(negedge CLK); #1;
    total++; if (bus.err_count !== exp_err) begin bad++; $display("FAIL inv_err got=%h exp=%h", bus.err_count, exp_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL inv_busy got=%b exp=0", bus.busy); end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK); drive(1'b1, 32'd1, 64'hC1, 4'h0);
    @(negedge CLK); drive(1'b1, 32'd3, 64'hC3, 4'h0);
    @(negedge CLK); drive(1'b0, '0, '0, 4'hF); RST = 1'b1; #1;
    total++; if (bus.req__ENA !== 4'b0 || bus.busy !== 1'b0 || bus.pipe_enq__RDY !== 1'b1 || bus.err_count !== 16'h0)
      begin bad++; $display("FAIL rstmid_during ena=%b busy=%b rdy=%b err=%h exp 0000/0/1/0000", bus.req__ENA, bus.busy, bus.pipe_enq__RDY, bus.err_count); end
    exp_err = '0;
    @(negedge CLK); RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK); #1;
      total++; if (bus.req__ENA !== 4'b0 || bus.busy !== 1'b0 || bus.pipe_enq__RDY !== 1'b1)
        begin bad++; $display("FAIL rstmid_after[%0d] ena=%b busy=%b rdy=%b exp 0000/0/1", i, bus.req__ENA, bus.busy, bus.pipe_enq__RDY); end
    end
  endtask

  task automatic test_random();
    logic        en, e_busy, e_rdy, drop;
    logic [31:0] id, idx;
    logic [63:0] pl, e_v;
    logic [3:0]  r, e_ena;
    q.delete();
    for (int c = 0; c < 400; c++) begin
      en = 1'($urandom_range(0, 1));
      id = 32'($urandom_range(0, 6));
      pl = {$urandom, $urandom};
      r  = 4'($urandom_range(0, 15));
      @(negedge CLK); drive(en, id, pl, r); #1;
      e_ena = '0; e_v = '0; drop = 1'b0;
      e_busy = (q.size() != 0);
      e_rdy  = (q.size() < DEPTH);
      if (e_busy) begin
        idx = q[0].id - 32'd1;
        e_v = q[0].pl;
        if (idx < NM) begin
          if (r[idx[1:0]]) e_ena[idx[1:0]] = 1'b1;
        end else drop = 1'b1;
      end
      total++; if (bus.req__ENA !== e_ena) begin bad++; $display("FAIL rnd_ena c=%0d got=%b exp=%b", c, bus.req__ENA, e_ena); end
      total++; if (bus.req_v !== e_v) begin bad++; $display("FAIL rnd_v c=%0d got=%h exp=%h", c, bus.req_v, e_v); end
      total++; if (bus.busy !== e_busy || bus.pipe_enq__RDY !== e_rdy)
        begin bad++; $display("FAIL rnd_flags c=%0d busy=%b rdy=%b exp %b/%b", c, bus.busy, bus.pipe_enq__RDY, e_busy, e_rdy); end
      total++; if (bus.err_count !== exp_err) begin bad++; $display("FAIL rnd_err c=%0d got=%h exp=%h", c, bus.err_count, exp_err); end
      if (e_ena != 4'b0 || drop) void'(q.pop_front());
      if (drop) exp_err = err_inc(exp_err);
      if (en && e_rdy) q.push_back('{id: id, pl: pl});
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge CLK); drive(1'b0, '0, '0, 4'hF);
    end
    q.delete();
  endtask

  task automatic test_saturate();
    for (int c = 0; c < 65540; c++) begin
      @(negedge CLK); drive(1'b1, 32'd0, 64'(c), 4'hF); #1;
      total++; if (bus.req__ENA !== 4'b0) begin bad++; $display("FAIL sat_ena c=%0d got=%b exp=0000", c, bus.req__ENA); end
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK); drive(1'b0, '0, '0, 4'hF);
    end
    #1;
`ifdef REQUEST_DISPATCH_ERRCNT_EN
    exp_err = 16'hFFFF;
`else
    exp_err = 16'h0;
`endif
    total++; if (bus.err_count !== exp_err) begin bad++; $display("FAIL sat_err got=%h exp=%h", bus.err_count, exp_err); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL sat_busy got=%b exp=0", bus.busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_invalid();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
